// File: rtl/pll_reconfig_seq_if.sv
// Handshake bundle between the mode-select logic, the per-mode table ROM and the PLL
// reconfiguration FIFO. "master" is the sequencer side, "slave" the surrounding system.
interface pll_reconfig_seq_if #(
  parameter int unsigned MODE_W = 2
);
  logic                req;
  logic [MODE_W-1:0]   mode;
  logic [MODE_W+5:0]   tbl_addr;
  logic [37:0]         tbl_data;
  logic [5:0]          pll_addr;
  logic [31:0]         pll_value;
  logic                pll_write;
  logic                pll_busy;
  logic                busy;
  logic                done;

  modport master (
    input  req, mode, tbl_data, pll_busy,
    output tbl_addr, pll_addr, pll_value, pll_write, busy, done
  );

  modport slave (
    output req, mode, tbl_data, pll_busy,
    input  tbl_addr, pll_addr, pll_value, pll_write, busy, done
  );
endinterface

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: mode write, NUM_WORDS table writes, start write, settle, done.
// Requests arriving while busy are held as a single pending request (last mode wins).
module pll_reconfig_seq #(
  parameter int unsigned MODE_W        = 2,
  parameter int unsigned NUM_WORDS     = 8,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input logic                clk,
  input logic                reset,
  pll_reconfig_seq_if.master bus
);

  localparam int unsigned     TblAddrW   = MODE_W + 6;
  localparam int unsigned     CntW       = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [5:0]      LastIdx    = 6'(NUM_WORDS - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StModeWr, StFetch, StDataWr, StStartWr, StSettle, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          idx_q, idx_d;
  logic [TblAddrW-1:0] tbl_addr_q, tbl_addr_d;
  logic                pend_q, pend_d;
  logic [MODE_W-1:0]   pend_mode_q, pend_mode_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                wr_state;
  logic                accept;
  logic                start;
  logic [MODE_W-1:0]   start_mode;

  function automatic logic [TblAddrW-1:0] base_addr(input logic [MODE_W-1:0] m);
    return TblAddrW'(m) * TblAddrW'(NUM_WORDS);
  endfunction

  // The FIFO strobe is gated by pll_busy in the same cycle so a full FIFO never sees a write.
  assign wr_state = (state_q == StModeWr) || (state_q == StDataWr) || (state_q == StStartWr);
  assign accept   = wr_state && !bus.pll_busy;

  assign bus.pll_write = accept;
  assign bus.pll_addr  = (state_q == StDataWr)  ? bus.tbl_data[37:32] :
                         (state_q == StStartWr) ? 6'd2 : 6'd0;
  assign bus.pll_value = (state_q == StDataWr)  ? bus.tbl_data[31:0] : 32'd0;
  assign bus.tbl_addr  = tbl_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tbl_addr_d  = tbl_addr_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    start       = 1'b0;
    start_mode  = bus.req ? bus.mode : pend_mode_q;

    if (bus.req && (state_q != StIdle)) begin
      pend_d      = 1'b1;
      pend_mode_d = bus.mode;
    end

    unique case (state_q)
      StIdle: start = bus.req || pend_q;
      StModeWr: begin
        if (accept) state_d = StFetch;
      end
      // tbl_addr is already stable; this cycle covers the registered ROM latency.
      StFetch: state_d = StDataWr;
      StDataWr: begin
        if (accept) begin
          if (idx_q == LastIdx) begin
            state_d = StStartWr;
          end else begin
            idx_d      = idx_q + 6'd1;
            tbl_addr_d = tbl_addr_q + TblAddrW'(1);
            state_d    = StFetch;
          end
        end
      end
      StStartWr: begin
        if (accept) begin
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        start = bus.req || pend_q;
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d    = StModeWr;
      busy_d     = 1'b1;
      idx_d      = '0;
      tbl_addr_d = base_addr(start_mode);
      pend_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      tbl_addr_q  <= '0;
      pend_q      <= 1'b0;
      pend_mode_q <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tbl_addr_q  <= tbl_addr_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  a_no_write_when_full: assert property (@(posedge clk) disable iff (reset)
    !(bus.pll_write && bus.pll_busy));

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: transaction-level model (write queue + earliest-cycle timing)
// checked every cycle on a NUM_WORDS=8 instance, plus literal checks and a NUM_WORDS=1 instance.
module tb_pll_reconfig_seq;

  localparam int NW = 8;
  localparam int SC = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  pll_reconfig_seq_if #(.MODE_W(2)) a_if ();
  pll_reconfig_seq_if #(.MODE_W(2)) b_if ();

  pll_reconfig_seq #(.MODE_W(2), .NUM_WORDS(NW), .SETTLE_CYCLES(SC)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  pll_reconfig_seq #(.MODE_W(2), .NUM_WORDS(1), .SETTLE_CYCLES(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  function automatic logic [37:0] rom_word(input int unsigned a);
    return {6'(a * 5 + 7), 32'hC0DE0000 ^ (a * 32'h00010203)};
  endfunction

  always @(posedge clk) a_if.tbl_data <= rom_word(int'(a_if.tbl_addr));
  always @(posedge clk) b_if.tbl_data <= rom_word(int'(b_if.tbl_addr));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  bit            armed = 1'b0;
  bit            m_active = 1'b0;
  logic [37:0]   m_q[$];
  int            m_item, m_next;
  int            m_done = -1;
  bit            m_pend = 1'b0;
  logic [1:0]    m_pend_mode;
  logic [37:0]   wr_log[$];
  int            wr_count = 0;
  int            done_cnt = 0;
  int            last_done = 0;
  int            now;
  bit            slot;

  function automatic void m_start(input logic [1:0] m, input int t);
    m_q.delete();
    m_q.push_back({6'd0, 32'd0});
    for (int i = 0; i < NW; i++) m_q.push_back(rom_word(int'(m) * NW + i));
    m_q.push_back({6'd2, 32'd0});
    m_item   = 0;
    m_next   = t + 1;
    m_done   = -1;
    m_active = 1'b1;
  endfunction

  // Per-cycle compare against the model, then advance the model past the next clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        now  = cyc;
        slot = m_active && (m_q.size() > 0) && (now >= m_next);
        chk("busy", a_if.busy, m_active && (m_done != now));
        chk("done", a_if.done, m_done == now);
        chk("pll_write", a_if.pll_write, slot && !a_if.pll_busy);
        if (slot) chk("pll_word", {a_if.pll_addr, a_if.pll_value}, m_q[0]);
        if (a_if.pll_write && !a_if.pll_busy) begin
          wr_log.push_back({a_if.pll_addr, a_if.pll_value});
          wr_count++;
        end
        if (a_if.done) begin
          done_cnt++;
          last_done = now;
        end
        if (reset) begin
          m_active = 1'b0;
          m_q.delete();
          m_pend   = 1'b0;
          m_done   = -1;
        end else begin
          if (slot && !a_if.pll_busy) begin
            void'(m_q.pop_front());
            m_item++;
            if (m_item == NW + 2)      m_done = now + SC + 1;
            else if (m_item == NW + 1) m_next = now + 1;
            else                       m_next = now + 2;
          end
          if (!m_active) begin
            if (a_if.req) m_start(a_if.mode, now);
          end else if (m_done == now) begin
            if (a_if.req || m_pend) begin
              m_start(a_if.req ? a_if.mode : m_pend_mode, now);
              m_pend = 1'b0;
            end else begin
              m_active = 1'b0;
              m_done   = -1;
            end
          end else if (a_if.req) begin
            m_pend      = 1'b1;
            m_pend_mode = a_if.mode;
          end
        end
      end
    end
  end

  logic [37:0] b_log[$];
  int          b_done_cnt = 0;
  int          b_last_done = 0;
  always @(negedge clk) begin
    if (b_if.pll_write && !b_if.pll_busy) b_log.push_back({b_if.pll_addr, b_if.pll_value});
    if (b_if.done) begin
      b_done_cnt++;
      b_last_done = cyc;
    end
  end

  task automatic pulse_a(input logic [1:0] m);
    a_if.req  = 1'b1;
    a_if.mode = m;
    tick();
    a_if.req  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_done_seen"}, done_cnt != d0, 1);
  endtask

  task automatic wait_writes(input string nm, input int target, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (wr_count < target && n < budget);
    chk({nm, "_writes_seen"}, wr_count >= target, 1);
  endtask

  int r, w0, w1, d1, d0i;

  initial begin
    reset = 1'b1;
    a_if.req = 1'b0; a_if.mode = '0; a_if.pll_busy = 1'b0;
    b_if.req = 1'b0; b_if.mode = '0; b_if.pll_busy = 1'b0;
    repeat (3) tick();
    chk("rst_pll_write", a_if.pll_write, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_pll_addr", a_if.pll_addr, 0);
    chk("rst_pll_value", a_if.pll_value, 0);
    chk("rst_tbl_addr", a_if.tbl_addr, 0);
    reset = 1'b0;
    armed = 1'b1;
    repeat (2) tick();

    // Basic sequence, mode 1
    wr_log.delete();
    r = cyc;
    pulse_a(2'd1);
    wait_done("basic", 200);
    chk("basic_latency", last_done - r, 35);
    chk("basic_nwrites", wr_log.size(), 10);
    chk("basic_first", wr_log[0], {6'd0, 32'd0});
    chk("basic_entry0", wr_log[1], {6'h2F, 32'hC0D61018});
    chk("basic_last", wr_log[9], {6'd2, 32'd0});
    repeat (3) tick();

    // Backpressure: 5 stalled cycles while the 3rd table entry is being written
    wr_log.delete();
    w0 = wr_count;
    r = cyc;
    pulse_a(2'd0);
    wait_writes("bp", w0 + 3, 50);
    tick();
    a_if.pll_busy = 1'b1;
    repeat (5) tick();
    a_if.pll_busy = 1'b0;
    wait_done("bp", 200);
    chk("bp_latency", last_done - r, 40);
    chk("bp_nwrites", wr_log.size(), 10);
    chk("bp_entry2", wr_log[3], {6'h11, 32'hC0DC0406});
    repeat (3) tick();

    // Pending requests: mode 2 is overwritten by mode 3
    wr_log.delete();
    r = cyc;
    pulse_a(2'd1);
    repeat (4) tick();
    pulse_a(2'd2);
    repeat (6) tick();
    pulse_a(2'd3);
    wait_done("pend1", 200);
    chk("pend1_latency", last_done - r, 35);
    d1 = last_done;
    wait_done("pend2", 200);
    chk("pend2_latency", last_done - d1, 35);
    chk("pend_nwrites", wr_log.size(), 20);
    chk("pend_mode3_entry0", wr_log[11], {6'h3F, 32'hC0C63048});
    repeat (3) tick();

    // Reset after the 4th accepted write
    w0 = wr_count;
    pulse_a(2'd2);
    wait_writes("rstmid", w0 + 4, 50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_pll_write", a_if.pll_write, 0);
    chk("rstmid_busy", a_if.busy, 0);
    chk("rstmid_done", a_if.done, 0);
    w1 = wr_count;
    repeat (50) tick();
    chk("rstmid_no_writes", wr_count - w1, 0);
    pulse_a(2'd0);
    wait_done("rstmid_fresh", 200);
    chk("rstmid_fresh_nwrites", wr_count - w1, 10);
    repeat (3) tick();

    // Edge configuration instance: NUM_WORDS=1, SETTLE_CYCLES=1
    d0i = b_done_cnt;
    r = cyc;
    b_if.req = 1'b1;
    b_if.mode = 2'd3;
    tick();
    b_if.req = 1'b0;
    for (int n = 0; n < 50 && b_done_cnt == d0i; n++) tick();
    chk("edge_done_seen", b_done_cnt != d0i, 1);
    chk("edge_latency", b_last_done - r, 6);
    chk("edge_nwrites", b_log.size(), 3);
    chk("edge_entry0", b_log[1], {6'h16, 32'hC0DD0609});
    chk("edge_start", b_log[2], {6'd2, 32'd0});

    // Randomized traffic with backpressure, overlapping requests and rare resets
    for (int n = 0; n < 3000; n++) begin
      a_if.pll_busy = ($urandom_range(0, 9) < 3);
      a_if.req      = ($urandom_range(0, 99) < 3);
      a_if.mode     = 2'($urandom);
      reset         = ($urandom_range(0, 999) == 0);
      tick();
    end
    a_if.req = 1'b0;
    a_if.pll_busy = 1'b0;
    reset = 1'b0;
    for (int n = 0; n < 300 && (a_if.busy === 1'b1 || m_active); n++) tick();
    chk("drain_idle", a_if.busy, 0);

    // Long idle
    repeat (2) tick();
    d0i = done_cnt;
    w0 = wr_count;
    repeat (1000) tick();
    chk("idle_no_done", done_cnt - d0i, 0);
    chk("idle_no_writes", wr_count - w0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
Sequences PLL reconfiguration writes for video-mode changes. On a request it reads a per-mode table of (register address, value) pairs and pushes them into the clock-domain-crossing PLL FIFO, framed by a mode-register write and a start-register write. It then waits a settle interval and reports completion. It sits in the system block, between the mode-select logic and the pll_addr/pll_value/pll_write/pll_busy interface.

Parameters:
MODE_W, 2, width of mode index; up to 2^MODE_W modes
NUM_WORDS, 8, table entries per mode (1..63)
SETTLE_CYCLES, 1024, clk cycles to wait after start write before done (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
req  in  1  single-cycle reconfiguration request
mode  in  MODE_W  mode index, sampled when req=1
tbl_addr  out  MODE_W+6  table ROM address = mode*NUM_WORDS + idx
tbl_data  in  38  {addr[37:32], value[31:0]}, valid one cycle after tbl_addr (registered ROM)
pll_addr  out  6  PLL reconfig register address
pll_value  out  32  PLL reconfig register data
pll_write  out  1  FIFO write strobe
pll_busy  in  1  FIFO full; a write is accepted only when pll_write=1 and pll_busy=0
busy  out  1  high from request acceptance until done
done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset: state IDLE; pll_write=0, busy=0, done=0, pll_addr=0, pll_value=0, tbl_addr=0, pending cleared, idx=0. Reset mid-sequence aborts immediately with no further writes; partial FIFO contents are the caller's concern, and the caller re-requests.
- pll_write is asserted only in a write state with valid data and pll_busy=0. Never assert it while pll_busy=1. A write is accepted in the cycle it is asserted.
- States:
  - IDLE: on req (or a pending request), latch mode, idx=0, busy=1 -> MODE_WR.
  - MODE_WR: pll_addr=0, pll_value=0 (waitrequest mode). Drive tbl_addr for idx 0. On accept -> FETCH.
  - FETCH: one wait cycle for ROM latency -> DATA_WR.
  - DATA_WR: pll_addr/pll_value = tbl_data fields, held stable while stalled. On accept: if idx==NUM_WORDS-1 -> START_WR; else idx+1, update tbl_addr -> FETCH.
  - START_WR: pll_addr=2, pll_value=0. On accept load settle counter = SETTLE_CYCLES-1 -> SETTLE.
  - SETTLE: decrement the counter; at 0 -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Total writes per sequence = NUM_WORDS+2.
- With pll_busy held 0: MODE_WR 1 cycle, then 2 cycles per entry, START_WR 1 cycle, SETTLE_CYCLES cycles, DONE 1 cycle. Req-to-done latency is 2*NUM_WORDS+SETTLE_CYCLES+3 cycles.
- req while busy: latched as pending with its mode; later requests overwrite the pending mode (last wins). A pending request starts in the cycle after DONE; busy may drop for exactly the DONE cycle.
- req in the same cycle as DONE: becomes pending and starts next cycle.
- req coincident with reset: ignored.
- tbl_addr arithmetic is width MODE_W+6 with no wrap. NUM_WORDS<=63 guarantees fit.

Test Plan:
- Basic: NUM_WORDS=8, SETTLE_CYCLES=16, pll_busy=0, req with mode=1 -> 10 writes: (0,0), entries at tbl_addr 8..15 in order, (2,0). done pulses exactly 35 cycles after req. busy high from the cycle after req until done.
- Backpressure: mode=0, pll_busy=1 for 5 cycles during the 3rd entry -> pll_write=0 throughout the stall. pll_addr/pll_value stay constant. The write completes on the first cycle pll_busy=0. The write sequence is unchanged and latency grows by exactly 5.
- Pending requests: during a mode=1 sequence, issue req mode=2 then req mode=3 -> the first sequence completes unchanged. A second sequence with tbl_addr 24..31 (mode 3) starts the cycle after done. Mode 2 is never executed.
- Reset mid-sequence: assert reset after the 4th accepted write -> the next cycle shows pll_write=0, busy=0, done=0, with no further writes. A fresh req mode=0 then yields a complete 10-write sequence.
- Edge config: NUM_WORDS=1, SETTLE_CYCLES=1 -> exactly 3 writes; done 6 cycles after req.
- Idle check: no req for 1000 cycles -> pll_write, busy and done stay 0.
